pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Parametrised program-counter unit for the pipelined MIPS datapath, replacing the combinational PC-plus-4 adder in the fetch stage. Holds the PC register, selects the next fetch address each cycle from sequential increment, hold (stall), resolved branch/jump redirect, or a return-address-stack (RAS) prediction. It sits between the hazard/branch-resolution logic and the instruction memory address port.

## Interface
Parameters:
- WIDTH, 32, PC and address width in bits
- INCR, 4, sequential increment in bytes
- RESET_PC, 0, PC value loaded on reset
- RAS_DEPTH, 4, number of RAS entries (power of two, ≥2)

Ports:
- Clk  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high reset
- Stall_PC  in  1  hold PC (load-use or structural hazard)
- Redirect  in  1  resolved branch/jump taken, from EX
- RedirectTarget  in  WIDTH  address to fetch after redirect
- Call  in  1  jal/jalr decoded in ID; push LinkAddr
- LinkAddr  in  WIDTH  return address to push
- Return  in  1  jr $ra decoded in ID; pop and predict
- PC  out  WIDTH  current fetch address (registered)
- PCPlusIncr  out  WIDTH  PC + INCR, combinational
- RasEmpty  out  1  RAS holds no entries
- RasFull  out  1  RAS holds RAS_DEPTH entries

## Operation
- Next-PC priority, highest first: Reset → RESET_PC; Redirect → RedirectTarget; Return with RAS non-empty and Stall_PC=0 → RAS top; Stall_PC → hold PC; otherwise → PC + INCR.
- Redirect overrides Stall_PC (flush beats stall).
- Arithmetic modulo 2^WIDTH: PC = 2^WIDTH − INCR increments to 0, no flag.
- RAS is a circular buffer: top pointer plus occupancy count 0..RAS_DEPTH.
- Push (Call=1, Stall_PC=0, Redirect=0): write LinkAddr at top+1, count saturates at RAS_DEPTH; when full, the oldest entry is silently overwritten.
- Pop (Return=1, Stall_PC=0, Redirect=0, count>0): next PC = top entry, top−1, count−1.
- Return with RAS empty: no prediction, normal increment; no pop.
- Call and Return in the same cycle: next PC = old top, top entry replaced by LinkAddr, count unchanged (if empty: push only, PC increments).
- Redirect or Stall_PC suppresses both push and pop that cycle.
- RAS mispredictions are corrected by the branch unit asserting Redirect; the RAS is not repaired.

## Timing
- PC, RAS pointer, count update on the rising edge of Clk; one-cycle latency from any input to PC.
- Reset (synchronous): PC = RESET_PC, count = 0, top = 0, RasEmpty = 1, RasFull = 0; RAS storage contents are don't-care. Reset asserted mid-operation discards all pending pushes/pops that cycle.
- PCPlusIncr tracks PC combinationally within the same cycle.
- RasEmpty/RasFull are derived from the registered count; they reflect the count after the last edge.

## Configuration
- PC_SEQ_RAS_EN defined: RAS storage and push/pop logic compiled in as described.
- Undefined: no RAS; Call, LinkAddr, Return ignored; next-PC priority is Reset, Redirect, Stall_PC, increment; RasEmpty tied 1, RasFull tied 0.

## Structure
- Package pc_seq_pkg: next-PC source enum (SRC_RESET, SRC_REDIRECT, SRC_RETURN, SRC_HOLD, SRC_SEQ) and default parameter constants.
- One sub-module: pc_ras_stack (circular buffer, push/pop/swap, count, empty/full), instantiated only under PC_SEQ_RAS_EN.

## Test plan
- Reset then 4 free-running cycles, RESET_PC=0x0040_0000 → PC 0x0040_0000, 0x0040_0004, 0x0040_0008, 0x0040_000C; PCPlusIncr always PC+4.
- Stall_PC=1 for 3 cycles at PC=0x100 → PC holds 0x100; Redirect=1 to 0x200 while stalled → PC=0x200 next cycle.
- PC=0xFFFF_FFFC, no stall → PC wraps to 0x0000_0000.
- Call LinkAddr=0x1004 then 0x2008; Return twice → PC 0x2008 then 0x1004; third Return with RasEmpty=1 → PC increments.
- RAS_DEPTH=4: five Calls 0x10..0x50 → RasFull=1 after fourth; four Returns yield 0x50,0x40,0x30,0x20 (0x10 overwritten).
- Call 0x3000 + Return same cycle with top 0x1004 → PC=0x1004, count unchanged, next Return → 0x3000; Reset mid-sequence → PC=RESET_PC, RasEmpty=1.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and default parameters for the pc_sequencer fetch-address unit.
package pc_seq_pkg;

  typedef enum logic [2:0] {
    SRC_RESET    = 3'd0,
    SRC_REDIRECT = 3'd1,
    SRC_RETURN   = 3'd2,
    SRC_HOLD     = 3'd3,
    SRC_SEQ      = 3'd4
  } next_src_e;

  localparam int unsigned PC_SEQ_WIDTH     = 32;
  localparam int unsigned PC_SEQ_INCR      = 4;
  localparam int unsigned PC_SEQ_RESET_PC  = 0;
  localparam int unsigned PC_SEQ_RAS_DEPTH = 4;

endpackage

// File: rtl/pc_ras_stack.sv
// Circular return-address stack: push, pop, and push+pop swap of the top entry.
// The oldest entry is silently overwritten when pushing into a full stack.
module pc_ras_stack #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic [WIDTH-1:0] top_data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    top_q, top_d;
  logic [CW-1:0]    count_q, count_d;

  assign empty_o    = (count_q == CW'(0));
  assign full_o     = (count_q == CW'(DEPTH));
  assign top_data_o = mem_q[top_q];

  // Next-state for pointer, occupancy and storage
  always_comb begin
    mem_d   = mem_q;
    top_d   = top_q;
    count_d = count_q;
    if (push_i && pop_i && !empty_o) begin
      mem_d[top_q] = push_data_i;
    end else if (pop_i && !empty_o) begin
      top_d   = top_q - PW'(1);
      count_d = count_q - CW'(1);
    end else if (push_i) begin
      top_d        = top_q + PW'(1);
      mem_d[top_d] = push_data_i;
      if (!full_o) begin
        count_d = count_q + CW'(1);
      end else begin
        count_d = count_q;
      end
    end else begin
      top_d = top_q;
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (reset) begin
      top_q   <= '0;
      count_q <= '0;
    end else begin
      top_q   <= top_d;
      count_q <= count_d;
    end
  end

  // Storage contents need no reset value
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter unit: selects next fetch address from reset, redirect, RAS, hold or increment.
// Optional return-address stack is compiled in when PC_SEQ_RAS_EN is defined.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned         WIDTH     = PC_SEQ_WIDTH,
  parameter int unsigned         INCR      = PC_SEQ_INCR,
  parameter logic [WIDTH-1:0]    RESET_PC  = WIDTH'(PC_SEQ_RESET_PC),
  parameter int unsigned         RAS_DEPTH = PC_SEQ_RAS_DEPTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Stall_PC,
  input  logic             Redirect,
  input  logic [WIDTH-1:0] RedirectTarget,
  input  logic             Call,
  input  logic [WIDTH-1:0] LinkAddr,
  input  logic             Return,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PCPlusIncr,
  output logic             RasEmpty,
  output logic             RasFull
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] ras_top_s;
  logic             ras_empty_s;
  logic             ras_full_s;
  logic             ras_hit_s;
  next_src_e        src_s;

`ifdef PC_SEQ_RAS_EN
  logic push_s;
  logic pop_s;

  // Redirect and stall both squash stack updates for the cycle
  assign push_s    = Call & ~Stall_PC & ~Redirect;
  assign pop_s     = Return & ~Stall_PC & ~Redirect;
  assign ras_hit_s = Return & ~Stall_PC & ~ras_empty_s;

  pc_ras_stack #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk         (Clk),
    .reset       (Reset),
    .push_i      (push_s),
    .pop_i       (pop_s),
    .push_data_i (LinkAddr),
    .top_data_o  (ras_top_s),
    .empty_o     (ras_empty_s),
    .full_o      (ras_full_s)
  );
`else
  logic unused_ras_inputs;

  assign unused_ras_inputs = ^{Call, Return, LinkAddr};
  assign ras_top_s         = '0;
  assign ras_empty_s       = 1'b1;
  assign ras_full_s        = 1'b0;
  assign ras_hit_s         = 1'b0;
`endif

  assign PC         = pc_q;
  assign PCPlusIncr = pc_q + WIDTH'(INCR);
  assign RasEmpty   = ras_empty_s;
  assign RasFull    = ras_full_s;

  // Next-PC source priority; flush beats a stall
  always_comb begin
    src_s = SRC_SEQ;
    if (Reset) begin
      src_s = SRC_RESET;
    end else if (Redirect) begin
      src_s = SRC_REDIRECT;
    end else if (ras_hit_s) begin
      src_s = SRC_RETURN;
    end else if (Stall_PC) begin
      src_s = SRC_HOLD;
    end else begin
      src_s = SRC_SEQ;
    end
  end

  // Next-PC mux
  always_comb begin
    pc_d = PCPlusIncr;
    case (src_s)
      SRC_RESET:    pc_d = RESET_PC;
      SRC_REDIRECT: pc_d = RedirectTarget;
      SRC_RETURN:   pc_d = ras_top_s;
      SRC_HOLD:     pc_d = pc_q;
      SRC_SEQ:      pc_d = PCPlusIncr;
      default:      pc_d = PCPlusIncr;
    endcase
  end

  // PC register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer; expectations adapt to whether PC_SEQ_RAS_EN is defined.
module tb_pc_sequencer;

  localparam logic [31:0] RST_PC = 32'h0040_0000;
`ifdef PC_SEQ_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] plus;
    logic        empty;
    logic        full;
  } obs_t;

  logic        Clk = 1'b0;
  logic        Reset, Stall_PC, Redirect, Call, Return;
  logic [31:0] RedirectTarget, LinkAddr;
  logic [31:0] PC, PCPlusIncr;
  logic        RasEmpty, RasFull;

  int   n_checks = 0;
  int   n_pass   = 0;
  obs_t exp_q[$];

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_ras [4];
  int          m_top;
  int          m_cnt;

  always #5 Clk = ~Clk;

  pc_sequencer #(
    .WIDTH     (32),
    .INCR      (4),
    .RESET_PC  (RST_PC),
    .RAS_DEPTH (4)
  ) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .Stall_PC       (Stall_PC),
    .Redirect       (Redirect),
    .RedirectTarget (RedirectTarget),
    .Call           (Call),
    .LinkAddr       (LinkAddr),
    .Return         (Return),
    .PC             (PC),
    .PCPlusIncr     (PCPlusIncr),
    .RasEmpty       (RasEmpty),
    .RasFull        (RasFull)
  );

  task automatic drive(input logic rst, input logic st, input logic rd, input logic [31:0] tgt,
                       input logic cl, input logic [31:0] lk, input logic rt);
    obs_t e;
    @(negedge Clk);
    Reset = rst; Stall_PC = st; Redirect = rd; RedirectTarget = tgt;
    Call = cl; LinkAddr = lk; Return = rt;
    if (rst) begin
      m_pc = RST_PC; m_top = 0; m_cnt = 0;
    end else if (rd) begin
      m_pc = tgt;
    end else if (st) begin
      m_pc = m_pc;
    end else if (RAS_EN && rt && m_cnt > 0) begin
      m_pc = m_ras[m_top];
      if (cl) begin
        m_ras[m_top] = lk;
      end else begin
        m_top = (m_top + 3) % 4;
        m_cnt = m_cnt - 1;
      end
    end else begin
      m_pc = m_pc + 32'd4;
      if (RAS_EN && cl) begin
        m_top = (m_top + 1) % 4;
        m_ras[m_top] = lk;
        if (m_cnt < 4) m_cnt = m_cnt + 1;
      end
    end
    e.pc    = m_pc;
    e.plus  = m_pc + 32'd4;
    e.empty = RAS_EN ? (m_cnt == 0) : 1'b1;
    e.full  = RAS_EN ? (m_cnt == 4) : 1'b0;
    exp_q.push_back(e);
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t e, o;
    for (int i = 0; i < 5; i++) begin
      drive(i == 0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      e = exp_q.pop_front();
      o = '{PC, PCPlusIncr, RasEmpty, RasFull};
      n_checks++;
      if (o !== e) $display("FAIL reset_seq[%0d] got pc=%h plus=%h e=%b f=%b want pc=%h plus=%h e=%b f=%b",
                            i, o.pc, o.plus, o.empty, o.full, e.pc, e.plus, e.empty, e.full);
      else n_pass++;
    end
  endtask

  task automatic test_stall_redirect();
    obs_t e, o;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0:       drive(1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
        4:       drive(1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0);
        default: drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      endcase
      e = exp_q.pop_front();
      o = '{PC, PCPlusIncr, RasEmpty, RasFull};
      n_checks++;
      if (o !== e) $display("FAIL stall_redirect[%0d] got pc=%h plus=%h want pc=%h plus=%h",
                            i, o.pc, o.plus, e.pc, e.plus);
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    obs_t e, o;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, i == 0, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0);
      e = exp_q.pop_front();
      o = '{PC, PCPlusIncr, RasEmpty, RasFull};
      n_checks++;
      if (o !== e) $display("FAIL wrap[%0d] got pc=%h plus=%h want pc=%h plus=%h",
                            i, o.pc, o.plus, e.pc, e.plus);
      else n_pass++;
    end
  endtask

  task automatic test_ras_basic();
    obs_t e, o;
    logic [31:0] lk [5] = '{32'h1004, 32'h2008, 32'h0, 32'h0, 32'h0};
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, i < 2, lk[i], i >= 2);
      e = exp_q.pop_front();
      o = '{PC, PCPlusIncr, RasEmpty, RasFull};
      n_checks++;
      if (o !== e) $display("FAIL ras_basic[%0d] got pc=%h e=%b f=%b want pc=%h e=%b f=%b",
                            i, o.pc, o.empty, o.full, e.pc, e.empty, e.full);
      else n_pass++;
    end
  endtask

  task automatic test_ras_overflow();
    obs_t e, o;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, i < 5, 32'(16 * (i + 1)), i >= 5);
      e = exp_q.pop_front();
      o = '{PC, PCPlusIncr, RasEmpty, RasFull};
      n_checks++;
      if (o !== e) $display("FAIL ras_overflow[%0d] got pc=%h e=%b f=%b want pc=%h e=%b f=%b",
                            i, o.pc, o.empty, o.full, e.pc, e.empty, e.full);
      else n_pass++;
    end
  endtask

  task automatic test_call_return_same();
    obs_t e, o;
    for (int i = 0; i < 7; i++) begin
      case (i)
        0:       drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1004, 1'b0);
        1:       drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h3000, 1'b1);
        2:       drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        3:       drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h7000, 1'b0);
        4:       drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h5000, 1'b0);
        5:       drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h6000, 1'b1);
        default: drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      endcase
      e = exp_q.pop_front();
      o = '{PC, PCPlusIncr, RasEmpty, RasFull};
      n_checks++;
      if (o !== e) $display("FAIL call_return_same[%0d] got pc=%h e=%b f=%b want pc=%h e=%b f=%b",
                            i, o.pc, o.empty, o.full, e.pc, e.empty, e.full);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    obs_t e, o;
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 39) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0,
            {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, $urandom_range(0, 2) == 0,
            {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, $urandom_range(0, 2) == 0);
      e = exp_q.pop_front();
      o = '{PC, PCPlusIncr, RasEmpty, RasFull};
      n_checks++;
      if (o !== e) $display("FAIL random[%0d] got pc=%h plus=%h e=%b f=%b want pc=%h plus=%h e=%b f=%b",
                            i, o.pc, o.plus, o.empty, o.full, e.pc, e.plus, e.empty, e.full);
      else n_pass++;
    end
  endtask

  initial begin
    Reset = 1'b1; Stall_PC = 1'b0; Redirect = 1'b0; RedirectTarget = 32'h0;
    Call = 1'b0; LinkAddr = 32'h0; Return = 1'b0;
    m_pc = RST_PC; m_top = 0; m_cnt = 0;
    for (int i = 0; i < 4; i++) m_ras[i] = 32'h0;
    test_reset();
    test_stall_redirect();
    test_wrap();
    test_ras_basic();
    test_ras_overflow();
    test_call_return_same();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
